// File: rtl/poly_tile_fifo.sv
// rtl/poly_tile_fifo.sv - tile FIFO between the polynomial multiplier and the relin unit
//
// Purpose: stores up to DEPTH tiles of TILE_WIDTH coefficients (plus a last flag)
// and presents the head tile first-word-fall-through to the relin unit.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   wr_valid/wr_ready        multiplier write handshake
//   wr_tile, wr_last         tile data and end-of-polynomial flag
//   inputs_ready_signal      head tile valid
//   poly_mult_outputs        head tile (zero when empty)
//   out_last                 last flag of head tile (zero when empty)
//   dequeue                  pop the head tile
//   count                    occupancy
//   overflow, underflow      sticky illegal-request flags
//   almost_full              count >= ALMOST_FULL_THRESH (only with POLY_TILE_FIFO_ALMOST_FULL_EN)
//
// Optional feature macro: POLY_TILE_FIFO_ALMOST_FULL_EN

module poly_tile_fifo #(
   parameter int DATA_WIDTH         = 64,
   parameter int TILE_WIDTH         = 8,
   parameter int DEPTH              = 8,
   parameter int ALMOST_FULL_THRESH = 6
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wr_valid,
   output logic                                  wr_ready,
   input  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] wr_tile,
   input  logic                                  wr_last,
   output logic                                  inputs_ready_signal,
   output logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] poly_mult_outputs,
   output logic                                  out_last,
   input  logic                                  dequeue,
   output logic [$clog2(DEPTH):0]                count,
   output logic                                  overflow,
   output logic                                  underflow
`ifdef POLY_TILE_FIFO_ALMOST_FULL_EN
   ,
   output logic                                  almost_full
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = TILE_WIDTH * DATA_WIDTH + 1;
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   // Status flags come from the registered count only, so neither handshake
   // input can ripple combinationally into wr_ready or inputs_ready_signal.
   assign wr_ready            = (count != FULL_COUNT);
   assign inputs_ready_signal = (count != '0);

   assign push = wr_valid && wr_ready;
   assign pop  = dequeue && inputs_ready_signal;

   // Storage is deliberately not reset; the empty mask on the output hides
   // whatever stale entries remain after a flush.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {wr_last, wr_tile};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_valid && !wr_ready) begin
            overflow <= 1'b1;
         end
         if (dequeue && !inputs_ready_signal) begin
            underflow <= 1'b1;
         end
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      out_last          = 1'b0;
      poly_mult_outputs = '0;
      if (inputs_ready_signal) begin
         {out_last, poly_mult_outputs} = head;
      end
   end

`ifdef POLY_TILE_FIFO_ALMOST_FULL_EN
   localparam logic [AW:0] AF_COUNT = (AW + 1)'(ALMOST_FULL_THRESH);
   assign almost_full = (count >= AF_COUNT);
`endif

endmodule

// File: tb/tb_poly_tile_fifo.sv
// tb/tb_poly_tile_fifo.sv - scoreboard testbench for poly_tile_fifo

module tb_poly_tile_fifo;

   typedef logic [7:0][63:0] tile_t;
   typedef logic [512:0]     entry_t;

   logic        clk;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   tile_t       wr_tile;
   logic        wr_last;
   logic        inputs_ready_signal;
   tile_t       poly_mult_outputs;
   logic        out_last;
   logic        dequeue;
   logic [3:0]  count;
   logic        overflow;
   logic        underflow;
`ifdef POLY_TILE_FIFO_ALMOST_FULL_EN
   logic        almost_full;
`endif

   int     checks;
   int     errors;
   entry_t sb[$];
   int     mcount;
   bit     exp_ovf;
   bit     exp_unf;

   poly_tile_fifo #(
      .DATA_WIDTH(64),
      .TILE_WIDTH(8),
      .DEPTH(8),
      .ALMOST_FULL_THRESH(6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_tile(wr_tile),
      .wr_last(wr_last),
      .inputs_ready_signal(inputs_ready_signal),
      .poly_mult_outputs(poly_mult_outputs),
      .out_last(out_last),
      .dequeue(dequeue),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
`ifdef POLY_TILE_FIFO_ALMOST_FULL_EN
      ,
      .almost_full(almost_full)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic tile_t seq_tile(input int t);
      tile_t r;
      for (int k = 0; k < 8; k++) r[k] = 64'(10 * t + k);
      return r;
   endfunction

   function automatic tile_t rand_tile();
      tile_t r;
      for (int k = 0; k < 8; k++) r[k] = {$urandom, $urandom};
      return r;
   endfunction

   // Drives one cycle of stimulus (called at negedge, returns at the next
   // negedge) and advances the reference model / scoreboard.
   task automatic drive(input bit wv, input bit wl, input tile_t t, input bit dq);
      bit do_push;
      bit do_pop;
      wr_valid = wv;
      wr_last  = wl;
      wr_tile  = t;
      dequeue  = dq;
      do_push  = wv && (mcount != 8);
      do_pop   = dq && (mcount != 0);
      if (wv && !do_push) exp_ovf = 1'b1;
      if (dq && mcount == 0) exp_unf = 1'b1;
      @(posedge clk);
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back({wl, t});
      mcount = mcount + int'(do_push) - int'(do_pop);
      @(negedge clk);
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      dequeue  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (inputs_ready_signal !== 1'b0) begin errors++; $display("FAIL reset_irs: got %b want 0", inputs_ready_signal); end
      checks++; if (poly_mult_outputs !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", poly_mult_outputs); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); end
`ifdef POLY_TILE_FIFO_ALMOST_FULL_EN
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
`endif
   endtask

   task automatic test_order();
      entry_t exp;
      for (int t = 0; t < 3; t++) begin
         drive(1'b1, t == 2, seq_tile(t), 1'b0);
         if (t == 0) begin
            checks++; if (inputs_ready_signal !== 1'b1) begin errors++; $display("FAIL order_latency: irs got %b want 1", inputs_ready_signal); end
         end
      end
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL order_count3: got %0d want 3", count); end
      for (int t = 0; t < 3; t++) begin
         exp = sb[0];
         checks++; if ({out_last, poly_mult_outputs} !== exp) begin errors++; $display("FAIL order_head%0d: got %h want %h", t, {out_last, poly_mult_outputs}, exp); end
         checks++; if (out_last !== (t == 2)) begin errors++; $display("FAIL order_last%0d: got %b want %b", t, out_last, t == 2); end
         drive(1'b0, 1'b0, '0, 1'b1);
      end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL order_drained: got %0d want 0", count); end
      checks++; if (poly_mult_outputs !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL order_empty_mask: got %h want 0", {out_last, poly_mult_outputs}); end
   endtask

   task automatic test_full();
      entry_t exp;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, i[0], rand_tile(), 1'b0);
         checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL full_count%0d: got %0d want %0d", i, count, i + 1); end
         checks++; if (wr_ready !== (i != 7)) begin errors++; $display("FAIL full_wr_ready%0d: got %b want %b", i, wr_ready, i != 7); end
`ifdef POLY_TILE_FIFO_ALMOST_FULL_EN
         checks++; if (almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL full_almost%0d: got %b want %b", i, almost_full, i + 1 >= 6); end
`endif
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
      drive(1'b1, 1'b1, rand_tile(), 1'b0);
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL full_ovf: got %b want %b", overflow, exp_ovf); end
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count_after_ovf: got %0d want 8", count); end
      for (int i = 0; i < 8; i++) begin
         exp = sb[0];
         checks++; if ({out_last, poly_mult_outputs} !== exp) begin errors++; $display("FAIL full_drain%0d: got %h want %h", i, {out_last, poly_mult_outputs}, exp); end
         drive(1'b0, 1'b0, '0, 1'b1);
      end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_underflow();
      entry_t exp;
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_initial: got %b want 0", underflow); end
      drive(1'b0, 1'b0, '0, 1'b1);
      checks++; if (underflow !== exp_unf) begin errors++; $display("FAIL unf_set: got %b want %b", underflow, exp_unf); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL unf_count: got %0d want 0", count); end
      // A moved read pointer would expose a stale slot instead of this tile.
      drive(1'b1, 1'b0, rand_tile(), 1'b0);
      exp = sb[0];
      checks++; if ({out_last, poly_mult_outputs} !== exp) begin errors++; $display("FAIL unf_rd_ptr: got %h want %h", {out_last, poly_mult_outputs}, exp); end
      drive(1'b0, 1'b0, '0, 1'b1);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky: got %b want 1", underflow); end
   endtask

   task automatic test_back_to_back();
      entry_t exp;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rand_tile(), 1'b0);
      for (int i = 0; i < 20; i++) begin
         exp = sb[0];
         checks++; if ({out_last, poly_mult_outputs} !== exp) begin errors++; $display("FAIL b2b_head%0d: got %h want %h", i, {out_last, poly_mult_outputs}, exp); end
         checks++; if (count !== 4'd3) begin errors++; $display("FAIL b2b_count%0d: got %0d want 3", i, count); end
         drive(1'b1, i[1], rand_tile(), 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         exp = sb[0];
         checks++; if ({out_last, poly_mult_outputs} !== exp) begin errors++; $display("FAIL b2b_tail%0d: got %h want %h", i, {out_last, poly_mult_outputs}, exp); end
         drive(1'b0, 1'b0, '0, 1'b1);
      end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_drained: got %0d want 0", count); end
   endtask

   task automatic test_reset_flush();
      entry_t exp;
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, rand_tile(), 1'b0);
      checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d want 5", count); end
      rst = 1'b1;
      #1;
      sb.delete();
      mcount  = 0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
      checks++; if (inputs_ready_signal !== 1'b0) begin errors++; $display("FAIL flush_irs: got %b want 0", inputs_ready_signal); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL flush_wr_ready: got %b want 1", wr_ready); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL flush_flags: got %b want 00", {overflow, underflow}); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drive(1'b1, 1'b1, rand_tile(), 1'b0);
      exp = sb[0];
      checks++; if ({out_last, poly_mult_outputs} !== exp) begin errors++; $display("FAIL flush_first: got %h want %h", {out_last, poly_mult_outputs}, exp); end
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL flush_count1: got %0d want 1", count); end
      drive(1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      mcount   = 0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      wr_tile  = '0;
      dequeue  = 1'b0;
      test_reset();
      test_order();
      test_full();
      test_underflow();
      test_back_to_back();
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/poly_tile_fifo.md
# poly_tile_fifo

Tile buffer between the polynomial multiplier and the relinearization unit. Accepts one tile of `TILE_WIDTH` coefficients per cycle from the multiplier, stores up to `DEPTH` tiles, and presents the head tile on `poly_mult_outputs` with `inputs_ready_signal`. The relin unit pops it by pulsing `dequeue`. This block is the producer end of the relin unit's `poly_mult_outputs` / `inputs_ready_signal` / `dequeue` handshake.

## Interface

- `DATA_WIDTH`, 64: coefficient width.
- `TILE_WIDTH`, 8: coefficients per tile. Must equal the relin unit's `RELIN_KEYS_TILE_WIDTH`.
- `DEPTH`, 8: tile slots. Power of two, ≥2.
- `ALMOST_FULL_THRESH`, 6: occupancy at which `almost_full` asserts. Range 1..DEPTH.

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: multiplier offers a tile.
- `wr_ready` out 1: space available (`count != DEPTH`).
- `wr_tile` in [TILE_WIDTH-1:0][DATA_WIDTH-1:0]: tile data.
- `wr_last` in 1: tile is the final tile of a polynomial.
- `inputs_ready_signal` out 1: head tile valid (`count != 0`).
- `poly_mult_outputs` out [TILE_WIDTH-1:0][DATA_WIDTH-1:0]: head tile. All zero when empty.
- `out_last` out 1: `wr_last` flag of the head tile. 0 when empty.
- `dequeue` in 1: pop the head tile.
- `count` out $clog2(DEPTH)+1: occupancy.
- `overflow` out 1: sticky. Set on `wr_valid && !wr_ready`.
- `underflow` out 1: sticky. Set on `dequeue && !inputs_ready_signal`.
- `almost_full` out 1: `count >= ALMOST_FULL_THRESH`. Present only with the macro (see Configuration).

## Operation

- Storage: circular buffer of `DEPTH` entries. Each entry is `TILE_WIDTH*DATA_WIDTH+1` bits (tile plus last flag).
- Pointers: `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrap modulo DEPTH. `count` is a separate register.
- Push: `push = wr_valid && wr_ready`. On push, write the entry at `wr_ptr`, then increment `wr_ptr`.
- Pop: `pop = dequeue && inputs_ready_signal`. On pop, increment `rd_ptr`.
- Count update: `count += push - pop`.
- Simultaneous push and pop:
  - Non-empty, not full: both occur; `count` is unchanged.
  - Full: `wr_ready` is 0, so only the pop occurs.
  - Empty: only the push occurs. There is no bypass.
- Illegal requests:
  - `dequeue` while empty is ignored (pointers and count unchanged) and sets `underflow`.
  - `wr_valid` while full drops the tile and sets `overflow`.
- Sticky flags clear only on reset.
- Output is first-word-fall-through: `poly_mult_outputs` and `out_last` are read combinationally from `mem[rd_ptr]`, masked to zero when `count == 0`.
- No data transformation: coefficients pass through bit-exact.

## Timing

- Reset (asynchronous, `rst` = 1) forces:
  - `wr_ptr = rd_ptr = count = 0`.
  - `overflow = underflow = 0`.
  - Outputs: `wr_ready = 1`, `inputs_ready_signal = 0`, `poly_mult_outputs = 0`, `out_last = 0`, `almost_full = 0`.
  - Memory contents are not cleared; the zero mask hides them.
- Reset mid-operation flushes every stored tile. `wr_ready` rises while `rst` is held.
- Write-to-read latency is 1 cycle: a tile pushed at edge N is visible with `inputs_ready_signal` = 1 after edge N.
- A pop at edge N exposes the next entry after edge N, so back-to-back pops drain one tile per cycle.
- `wr_ready`, `inputs_ready_signal` and `almost_full` are decoded from registered `count` only. They have no combinational path from `wr_valid` or `dequeue`.
- Throughput: 1 push and 1 pop per cycle, sustained.

## Configuration

- `POLY_TILE_FIFO_ALMOST_FULL_EN`
  - Defined: the `almost_full` port and its comparator exist. `almost_full` is registered-count derived and resets to 0.
  - Undefined: the port is absent and all other behaviour is identical.

## Test plan

- Reset then idle → `count` = 0, `inputs_ready_signal` = 0, `poly_mult_outputs` = 0, `wr_ready` = 1.
- Push tiles with coefficient k = 10·t + k, for t = 0..2, `wr_last` on t = 2, then `dequeue` each cycle:
  - Heads appear in order t = 0, 1, 2.
  - `out_last` = 1 only on t = 2.
  - `count` returns to 0.
- Fill to 8 tiles with `dequeue` low:
  - `wr_ready` = 0 at `count` = 8.
  - A ninth `wr_valid` sets `overflow`; the tile is not stored.
  - `almost_full` = 1 from `count` = 6 (macro defined).
- `dequeue` while empty → `underflow` = 1, `count` stays 0, `rd_ptr` unchanged.
- Steady push and pop for 20 cycles starting at `count` = 3:
  - `count` stays 3.
  - Data order is preserved across pointer wrap-around.
- Assert `rst` with 5 tiles queued → `count` = 0 and `inputs_ready_signal` = 0 immediately. After release, the next pushed tile is the first output.
